// File: rtl/ysyx_22040931_lsu.sv
`default_nettype none
// ============================================================================
// Module : ysyx_22040931_lsu
// Load/store stage: aligned data-memory requests, sub-word load/store lane
// handling and a registered write-back result.
// Rev    : 1.0
// ============================================================================
module ysyx_22040931_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              w_ena_i,
    input  logic [4:0]        w_addr_i,
    input  logic [63:0]       w_data_i,
    input  logic              mem_ena_i,
    input  logic              mem_wr_i,
    input  logic [2:0]        memrop_i,
    input  logic [2:0]        memwop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [63:0]       mem_data_i,
    input  logic [63:0]       pc_i,
    input  logic [31:0]       instr_i,
    output logic              dreq_valid,
    input  logic              dreq_ready,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic              dreq_wen,
    output logic [63:0]       dreq_wdata,
    output logic [7:0]        dreq_wstrb,
    input  logic              drsp_valid,
    input  logic [63:0]       drsp_rdata,
    output logic              wb_valid,
    output logic              w_ena,
    output logic [4:0]        w_addr,
    output logic [63:0]       w_data,
    output logic [63:0]       pc_o,
    output logic [31:0]       instr_o,
    output logic              misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Access size: 0 byte, 1 half, 2 word, 3 double (reserved codes -> double)
    function automatic logic [1:0] acc_size(input logic wr, input logic [2:0] rop,
                                            input logic [2:0] wop);
        logic [1:0] sz;
        sz = 2'd3;
        if (wr) begin
            case (wop)
                3'd0:    sz = SZ_B;
                3'd1:    sz = SZ_H;
                3'd2:    sz = SZ_W;
                default: sz = 2'd3;
            endcase
        end else begin
            case (rop)
                3'd0, 3'd4: sz = SZ_B;
                3'd1, 3'd5: sz = SZ_H;
                3'd2, 3'd6: sz = SZ_W;
                default:    sz = 2'd3;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] a);
        logic m;
        case (sz)
            SZ_B:    m = 1'b0;
            SZ_H:    m = a[0];
            SZ_W:    m = |a[1:0];
            default: m = |a[2:0];
        endcase
        return m;
    endfunction

    state_t state_q, state_d;

    logic              ex_w_ena_q;
    logic [4:0]        ex_w_addr_q;
    logic [63:0]       ex_w_data_q;
    logic              ex_mem_wr_q;
    logic [2:0]        ex_rop_q;
    logic [2:0]        ex_wop_q;
    logic [ADDR_W-1:0] ex_addr_q;
    logic [63:0]       ex_sdata_q;
    logic [63:0]       ex_pc_q;
    logic [31:0]       ex_instr_q;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_ena_q, wb_ena_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic [63:0] wb_pc_q, wb_pc_d;
    logic [31:0] wb_instr_q, wb_instr_d;
    logic        wb_mis_q, wb_mis_d;

    logic        w_accept;
    logic        w_in_mis;
    logic [1:0]  w_ex_size;
    logic [2:0]  w_k;
    logic [5:0]  w_shamt;
    logic [7:0]  w_strb;
    logic [63:0] w_lane_data;
    logic [63:0] w_rsh;
    logic [63:0] w_load_data;
    logic        w_req;

    assign in_ready  = (state_q == S_IDLE);
    assign w_accept  = in_valid && (state_q == S_IDLE);
    assign w_in_mis  = mem_ena_i &&
                       is_misaligned(acc_size(mem_wr_i, memrop_i, memwop_i), mem_addr_i[2:0]);
    assign w_ex_size = acc_size(ex_mem_wr_q, ex_rop_q, ex_wop_q);
    assign w_k       = ex_addr_q[2:0];
    assign w_shamt   = {w_k, 3'b000};
    assign w_rsh     = drsp_rdata >> w_shamt;
    assign w_req     = (state_q == S_REQ);

    always_comb begin
        w_strb      = 8'hFF;
        w_lane_data = ex_sdata_q;
        case (w_ex_size)
            SZ_B: begin
                w_strb      = 8'h01 << w_k;
                w_lane_data = {56'd0, ex_sdata_q[7:0]} << w_shamt;
            end
            SZ_H: begin
                w_strb      = 8'h03 << w_k;
                w_lane_data = {48'd0, ex_sdata_q[15:0]} << w_shamt;
            end
            SZ_W: begin
                w_strb      = 8'h0F << w_k;
                w_lane_data = {32'd0, ex_sdata_q[31:0]} << w_shamt;
            end
            default: begin
                w_strb      = 8'hFF;
                w_lane_data = ex_sdata_q;
            end
        endcase
    end

    always_comb begin
        w_load_data = w_rsh;
        case (ex_rop_q)
            3'd0:    w_load_data = {{56{w_rsh[7]}},  w_rsh[7:0]};
            3'd1:    w_load_data = {{48{w_rsh[15]}}, w_rsh[15:0]};
            3'd2:    w_load_data = {{32{w_rsh[31]}}, w_rsh[31:0]};
            3'd4:    w_load_data = {56'd0, w_rsh[7:0]};
            3'd5:    w_load_data = {48'd0, w_rsh[15:0]};
            3'd6:    w_load_data = {32'd0, w_rsh[31:0]};
            default: w_load_data = w_rsh;
        endcase
    end

    // Request fields come only from latched values so they stay stable in REQ
    assign dreq_valid = w_req;
    assign dreq_addr  = w_req ? {ex_addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign dreq_wen   = w_req && ex_mem_wr_q;
    assign dreq_wstrb = (w_req && ex_mem_wr_q) ? w_strb : 8'h00;
    assign dreq_wdata = (w_req && ex_mem_wr_q) ? w_lane_data : 64'd0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept && mem_ena_i && !w_in_mis) state_d = S_REQ;
            S_REQ:   if (dreq_ready) state_d = S_RESP;
            S_RESP:  if (drsp_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wb_valid_d = 1'b0;
        wb_ena_d   = wb_ena_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wb_pc_d    = wb_pc_q;
        wb_instr_d = wb_instr_q;
        wb_mis_d   = wb_mis_q;
        if (w_accept && (!mem_ena_i || w_in_mis)) begin
            wb_valid_d = 1'b1;
            wb_ena_d   = w_ena_i && (w_addr_i != 5'd0) && !w_in_mis;
            wb_addr_d  = w_addr_i;
            wb_data_d  = w_data_i;
            wb_pc_d    = pc_i;
            wb_instr_d = instr_i;
            wb_mis_d   = w_in_mis;
        end else if ((state_q == S_RESP) && drsp_valid) begin
            wb_valid_d = 1'b1;
            wb_ena_d   = ex_w_ena_q && (ex_w_addr_q != 5'd0);
            wb_addr_d  = ex_w_addr_q;
            wb_data_d  = ex_mem_wr_q ? ex_w_data_q : w_load_data;
            wb_pc_d    = ex_pc_q;
            wb_instr_d = ex_instr_q;
            wb_mis_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wb_valid_q <= 1'b0;
            wb_ena_q   <= 1'b0;
            wb_addr_q  <= 5'd0;
            wb_data_q  <= 64'd0;
            wb_pc_q    <= 64'd0;
            wb_instr_q <= 32'd0;
            wb_mis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_ena_q   <= wb_ena_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_pc_q    <= wb_pc_d;
            wb_instr_q <= wb_instr_d;
            wb_mis_q   <= wb_mis_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_w_ena_q  <= 1'b0;
            ex_w_addr_q <= 5'd0;
            ex_w_data_q <= 64'd0;
            ex_mem_wr_q <= 1'b0;
            ex_rop_q    <= 3'd0;
            ex_wop_q    <= 3'd0;
            ex_addr_q   <= '0;
            ex_sdata_q  <= 64'd0;
            ex_pc_q     <= 64'd0;
            ex_instr_q  <= 32'd0;
        end else if (w_accept) begin
            ex_w_ena_q  <= w_ena_i;
            ex_w_addr_q <= w_addr_i;
            ex_w_data_q <= w_data_i;
            ex_mem_wr_q <= mem_wr_i;
            ex_rop_q    <= memrop_i;
            ex_wop_q    <= memwop_i;
            ex_addr_q   <= mem_addr_i;
            ex_sdata_q  <= mem_data_i;
            ex_pc_q     <= pc_i;
            ex_instr_q  <= instr_i;
        end
    end

    assign wb_valid = wb_valid_q;
    assign w_ena    = wb_ena_q;
    assign w_addr   = wb_addr_q;
    assign w_data   = wb_data_q;
    assign pc_o     = wb_pc_q;
    assign instr_o  = wb_instr_q;
    assign misalign = wb_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040931_lsu.sv
`default_nettype none
// ============================================================================
// Module : tb_ysyx_22040931_lsu
// Directed stimulus with a write-back scoreboard for the load/store stage.
// Rev    : 1.0
// ============================================================================
module tb_ysyx_22040931_lsu;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              w_ena_i;
    logic [4:0]        w_addr_i;
    logic [63:0]       w_data_i;
    logic              mem_ena_i;
    logic              mem_wr_i;
    logic [2:0]        memrop_i;
    logic [2:0]        memwop_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [63:0]       mem_data_i;
    logic [63:0]       pc_i;
    logic [31:0]       instr_i;
    logic              dreq_valid;
    logic              dreq_ready;
    logic [ADDR_W-1:0] dreq_addr;
    logic              dreq_wen;
    logic [63:0]       dreq_wdata;
    logic [7:0]        dreq_wstrb;
    logic              drsp_valid;
    logic [63:0]       drsp_rdata;
    logic              wb_valid;
    logic              w_ena;
    logic [4:0]        w_addr;
    logic [63:0]       w_data;
    logic [63:0]       pc_o;
    logic [31:0]       instr_o;
    logic              misalign;

    ysyx_22040931_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .w_ena_i(w_ena_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
        .mem_ena_i(mem_ena_i), .mem_wr_i(mem_wr_i), .memrop_i(memrop_i),
        .memwop_i(memwop_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .pc_i(pc_i), .instr_i(instr_i),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
        .dreq_wen(dreq_wen), .dreq_wdata(dreq_wdata), .dreq_wstrb(dreq_wstrb),
        .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata),
        .wb_valid(wb_valid), .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
        .pc_o(pc_o), .instr_o(instr_o), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        w_ena;
        logic [4:0]  w_addr;
        logic [63:0] w_data;
        logic        chk_data;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
        int          cyc;
        int          id;
    } exp_t;

    typedef struct {
        logic [2:0]  wop;
        logic [31:0] addr;
        logic [63:0] sd;
        logic [7:0]  strb;
        logic [63:0] wd;
    } st_t;

    typedef struct {
        logic [2:0]  rop;
        logic [31:0] addr;
        logic [63:0] rd;
        logic [63:0] res;
    } ld_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_wb(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                             input logic chk, input logic [63:0] pc, input logic [31:0] ins,
                             input logic mis, input int lat, input int id);
        exp_t e;
        e.w_ena = we; e.w_addr = wa; e.w_data = wd; e.chk_data = chk;
        e.pc = pc; e.instr = ins; e.mis = mis; e.id = id;
        e.cyc = (lat < 0) ? -1 : cyc + lat;
        sb.push_back(e);
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                        input logic me, input logic wr, input logic [2:0] rop,
                        input logic [2:0] wop, input logic [31:0] addr,
                        input logic [63:0] sd, input logic [63:0] pc, input logic [31:0] ins);
        check("in_ready", in_ready, 1);
        w_ena_i = we; w_addr_i = wa; w_data_i = wd; mem_ena_i = me; mem_wr_i = wr;
        memrop_i = rop; memwop_i = wop; mem_addr_i = addr; mem_data_i = sd;
        pc_i = pc; instr_i = ins; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic mem_serve(input int rwait, input int rspwait, input logic [63:0] rd);
        dreq_ready = 1'b0;
        repeat (rwait) @(negedge clk);
        dreq_ready = 1'b1;
        @(negedge clk);
        dreq_ready = 1'b0;
        repeat (rspwait) @(negedge clk);
        drsp_valid = 1'b1;
        drsp_rdata = rd;
        @(negedge clk);
        drsp_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got wb_valid=1 required no pending result");
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("wb_ena[%0d]", mon_e.id), w_ena, mon_e.w_ena);
                check($sformatf("wb_addr[%0d]", mon_e.id), w_addr, mon_e.w_addr);
                if (mon_e.chk_data)
                    check($sformatf("wb_data[%0d]", mon_e.id), w_data, mon_e.w_data);
                check($sformatf("wb_pc_instr[%0d]", mon_e.id), {pc_o, instr_o},
                      {mon_e.pc, mon_e.instr});
                check($sformatf("wb_misalign[%0d]", mon_e.id), misalign, mon_e.mis);
                if (mon_e.cyc >= 0)
                    check($sformatf("wb_cycle[%0d]", mon_e.id), cyc, mon_e.cyc);
            end
        end
    end

    st_t st_tab[4];
    ld_t ld_tab[9];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; w_ena_i = 1'b0; w_addr_i = 5'd0; w_data_i = 64'd0;
        mem_ena_i = 1'b0; mem_wr_i = 1'b0; memrop_i = 3'd0; memwop_i = 3'd0;
        mem_addr_i = '0; mem_data_i = 64'd0; pc_i = 64'd0; instr_i = 32'd0;
        dreq_ready = 1'b0; drsp_valid = 1'b0; drsp_rdata = 64'd0;

        st_tab[0] = '{3'd1, 32'h1006, 64'hFFFF_FFFF_FFFF_BEEF, 8'hC0, 64'hBEEF_0000_0000_0000};
        st_tab[1] = '{3'd2, 32'h1004, 64'hFFFF_FFFF_DEAD_BEEF, 8'hF0, 64'hDEAD_BEEF_0000_0000};
        st_tab[2] = '{3'd3, 32'h1008, 64'h0102_0304_0506_0708, 8'hFF, 64'h0102_0304_0506_0708};
        st_tab[3] = '{3'd5, 32'h1010, 64'hA5A5_5A5A_1234_5678, 8'hFF, 64'hA5A5_5A5A_1234_5678};

        ld_tab[0] = '{3'd0, 32'h2005, 64'h0000_80FF_0000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        ld_tab[1] = '{3'd4, 32'h2005, 64'h0000_80FF_0000_0000, 64'h0000_0000_0000_0080};
        ld_tab[2] = '{3'd1, 32'h2006, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_FFFF_8765};
        ld_tab[3] = '{3'd5, 32'h2006, 64'h8765_4321_0000_0000, 64'h0000_0000_0000_8765};
        ld_tab[4] = '{3'd2, 32'h2004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321};
        ld_tab[5] = '{3'd6, 32'h2004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321};
        ld_tab[6] = '{3'd3, 32'h2008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        ld_tab[7] = '{3'd7, 32'h2010, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210};
        ld_tab[8] = '{3'd0, 32'h2000, 64'h1111_1111_1111_117F, 64'h0000_0000_0000_007F};

        repeat (3) @(negedge clk);
        check("rst_w", {w_ena, w_addr, w_data, misalign, wb_valid}, 0);
        check("rst_pc_instr", {pc_o, instr_o}, 0);
        check("rst_dreq", {dreq_valid, dreq_wen, dreq_wstrb, dreq_addr, dreq_wdata}, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Non-memory to x5, then to x0
        expect_wb(1, 5'd5, 64'h1234, 1, 64'h8000_0000, 32'h13, 0, 1, 1);
        send(1, 5'd5, 64'h1234, 0, 0, 3'd0, 3'd0, 32'h0, 64'h0, 64'h8000_0000, 32'h13);
        @(negedge clk);
        expect_wb(0, 5'd0, 64'h55, 1, 64'h8000_0004, 32'h93, 0, 1, 2);
        send(1, 5'd0, 64'h55, 0, 0, 3'd0, 3'd0, 32'h0, 64'h0, 64'h8000_0004, 32'h93);
        @(negedge clk);

        // SB with a stalled request and a stray response during REQ
        expect_wb(0, 5'd0, 64'h1003, 1, 64'h8000_0008, 32'h23, 0, 6, 3);
        send(0, 5'd0, 64'h1003, 1, 1, 3'd0, 3'd0, 32'h1003, 64'h1122_3344_5566_77AB,
             64'h8000_0008, 32'h23);
        check("sb_req", {dreq_valid, dreq_wen, dreq_wstrb, dreq_addr, dreq_wdata},
              {1'b1, 1'b1, 8'h08, 32'h1000, 64'h0000_0000_AB00_0000});
        dreq_ready = 1'b0;
        drsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drsp_valid = 1'b0;
            check($sformatf("sb_hold%0d", i),
                  {dreq_valid, dreq_wen, dreq_wstrb, dreq_addr, dreq_wdata},
                  {1'b1, 1'b1, 8'h08, 32'h1000, 64'h0000_0000_AB00_0000});
        end
        dreq_ready = 1'b1;
        @(negedge clk);
        dreq_ready = 1'b0;
        check("sb_req_done", dreq_valid, 0);
        drsp_valid = 1'b1;
        @(negedge clk);
        drsp_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            expect_wb(1, 5'd7, 64'h70 + 64'(i), 1, 64'h9000 + 64'(i), 32'h100 + 32'(i), 0, 4, 10 + i);
            send(1, 5'd7, 64'h70 + 64'(i), 1, 1, 3'd0, st_tab[i].wop, st_tab[i].addr,
                 st_tab[i].sd, 64'h9000 + 64'(i), 32'h100 + 32'(i));
            check($sformatf("st_req[%0d]", i),
                  {dreq_valid, dreq_wen, dreq_wstrb, dreq_addr, dreq_wdata},
                  {1'b1, 1'b1, st_tab[i].strb, st_tab[i].addr & 32'hFFFF_FFF8, st_tab[i].wd});
            mem_serve(0, 1, 64'hDEAD_DEAD_DEAD_DEAD);
        end

        for (int i = 0; i < 9; i++) begin
            expect_wb(1, 5'(10 + i), ld_tab[i].res, 1, 64'hA000 + 64'(i), 32'h3 + 32'(i), 0, 5, 20 + i);
            send(1, 5'(10 + i), 64'hBAD, 1, 0, ld_tab[i].rop, 3'd0, ld_tab[i].addr, 64'h0,
                 64'hA000 + 64'(i), 32'h3 + 32'(i));
            check($sformatf("ld_req[%0d]", i), {dreq_valid, dreq_wen, dreq_wstrb, dreq_addr},
                  {1'b1, 1'b0, 8'h00, ld_tab[i].addr & 32'hFFFF_FFF8});
            mem_serve(1, 1, ld_tab[i].rd);
        end

        // Misaligned LW and SD: no request, result flagged
        expect_wb(0, 5'd12, 64'h0, 0, 64'hB000, 32'h2003, 1, 1, 30);
        send(1, 5'd12, 64'hBAD, 1, 0, 3'd2, 3'd0, 32'h3002, 64'h0, 64'hB000, 32'h2003);
        check("mis_lw_noreq0", dreq_valid, 0);
        @(negedge clk);
        check("mis_lw_noreq1", dreq_valid, 0);
        expect_wb(0, 5'd13, 64'h0, 0, 64'hB004, 32'h3023, 1, 1, 31);
        send(1, 5'd13, 64'hBAD, 1, 1, 3'd0, 3'd3, 32'h4004, 64'h77, 64'hB004, 32'h3023);
        check("mis_sd_noreq", dreq_valid, 0);
        @(negedge clk);

        // Reset while waiting in RESP, then a stray response
        send(1, 5'd14, 64'h0, 1, 0, 3'd3, 3'd0, 32'h2008, 64'h0, 64'hC000, 32'h3003);
        dreq_ready = 1'b1;
        @(negedge clk);
        dreq_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rr_w", {w_ena, w_addr, w_data, misalign, wb_valid}, 0);
        check("rr_pc_instr", {pc_o, instr_o}, 0);
        check("rr_dreq", {dreq_valid, dreq_wen, dreq_wstrb, dreq_addr, dreq_wdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drsp_valid = 1'b1;
        drsp_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        drsp_valid = 1'b0;
        check("rr_after_w", {w_ena, w_addr, w_data, misalign, wb_valid}, 0);
        check("rr_after_pc", {pc_o, instr_o}, 0);
        check("rr_after_idle", {in_ready, dreq_valid}, 2'b10);
        @(negedge clk);

        // Back-to-back non-memory, then SD with zero-wait memory
        for (int i = 0; i < 3; i++) begin
            expect_wb(1, 5'(1 + i), 64'hF00 + 64'(i), 1, 64'hD000 + 64'(i), 32'h33, 0, 1, 40 + i);
            send(1, 5'(1 + i), 64'hF00 + 64'(i), 0, 0, 3'd0, 3'd0, 32'h0, 64'h0,
                 64'hD000 + 64'(i), 32'h33);
        end
        expect_wb(1, 5'd9, 64'h99, 1, 64'hE000, 32'h3023, 0, 3, 50);
        send(1, 5'd9, 64'h99, 1, 1, 3'd0, 3'd3, 32'h5000, 64'hCAFE_F00D_0000_1111,
             64'hE000, 32'h3023);
        check("sd_req", {dreq_valid, dreq_wen, dreq_wstrb, dreq_addr, dreq_wdata},
              {1'b1, 1'b1, 8'hFF, 32'h5000, 64'hCAFE_F00D_0000_1111});
        mem_serve(0, 0, 64'h0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22040931_lsu.md
# ysyx_22040931_lsu

Load/store stage directly downstream of the execute stage. It accepts one instruction per handshake, carrying EX results: register write info, memory opcodes, address and store data. Memory instructions go to the data memory over a valid/ready request and response channel. The block sub-word aligns the data, sign- or zero-extends loads, and presents a registered result to write-back. Non-memory instructions pass through with one cycle of latency.

## Interface
- `ADDR_W`, 32: memory address width.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: EX presents an instruction.
- `in_ready` output 1: stage can accept this cycle.
- `w_ena_i` input 1: register write enable from EX.
- `w_addr_i` input 5: destination register.
- `w_data_i` input 64: ALU result.
- `mem_ena_i` input 1: instruction accesses memory.
- `mem_wr_i` input 1: 1 = store, 0 = load.
- `memrop_i` input 3: load op. 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU. 7 is reserved and treated as LD.
- `memwop_i` input 3: store op. 0 SB, 1 SH, 2 SW, 3 SD. 4–7 are treated as SD.
- `mem_addr_i` input ADDR_W: byte address.
- `mem_data_i` input 64: store data, right-aligned.
- `pc_i` input 64 and `instr_i` input 32: carried through unchanged.
- `dreq_valid` output 1: memory request.
- `dreq_ready` input 1: memory accepts the request.
- `dreq_addr` output ADDR_W: address with bits [2:0] forced to 0.
- `dreq_wen` output 1: write request.
- `dreq_wdata` output 64: store data shifted to its byte lanes.
- `dreq_wstrb` output 8: byte-lane enables. All zero for reads.
- `drsp_valid` input 1: response present. Arrives for reads and for writes.
- `drsp_rdata` input 64: aligned 8-byte read data.
- `wb_valid` output 1: registered result valid. One-cycle pulse per instruction.
- `w_ena` output 1, `w_addr` output 5, `w_data` output 64, `pc_o` output 64, `instr_o` output 32: registered write-back fields.
- `misalign` output 1: accompanies `wb_valid` when the access was misaligned.

## Operation
- States: IDLE, REQ, RESP.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, latch all inputs.
  - Non-memory instruction: stay in IDLE and load the output register next edge.
  - Aligned memory access: go to REQ.
  - Misaligned access: no memory request. Load the output register with `w_ena` = 0 and `misalign` = 1.
- Misalignment rules:
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] ≠ 0.
  - Doubleword with addr[2:0] ≠ 0.
- REQ:
  - `dreq_valid` = 1. Request fields are driven from latched values and held stable until `dreq_ready`.
  - On `dreq_ready`, go to RESP.
- RESP:
  - Wait for `drsp_valid`, then load the output register and return to IDLE.
  - A `drsp_valid` arriving in IDLE or REQ is ignored.
- Store lanes, with k = addr[2:0]:
  - Byte: `wstrb` = 0x01<<k, data = byte<<(8k).
  - Half: `wstrb` = 0x03<<k.
  - Word: `wstrb` = 0x0F<<k.
  - Double: `wstrb` = 0xFF, data unshifted.
  - Stores produce `w_ena` = w_ena_i and `w_data` = w_data_i.
- Load result:
  - Shift `drsp_rdata` right by 8k, take the low 8/16/32/64 bits, then sign- or zero-extend per `memrop`.
  - The result replaces `w_data`. `w_ena` = w_ena_i.
- `w_ena` is forced to 0 whenever `w_addr_i` = 0.

## Timing
- Reset (async, `rst_n` low): state = IDLE.
- Every output register resets to 0: `wb_valid`, `w_ena`, `w_addr`, `w_data`, `pc_o`, `instr_o`, `misalign`.
- `dreq_*` outputs are 0 while in reset.
- Reset mid-transaction: the outstanding request or response is abandoned, and a later stray `drsp_valid` in IDLE is ignored.
- Latency:
  - Non-memory or misaligned: `wb_valid` one cycle after acceptance.
  - Memory access: `dreq_valid` rises the cycle after acceptance. `wb_valid` rises the cycle after `drsp_valid`.
  - Minimum memory latency is 3 cycles, with ready and response both same-cycle.
- `in_ready` is combinational from state only. There is no dependency on `in_valid`.
- `in_ready` is 0 in REQ and RESP, so back-to-back accept is possible only in IDLE.
- Write-back does not backpressure.
- `dreq_valid` must never drop before `dreq_ready` is seen.

## Test plan
- Non-memory: ALU result 0x1234 to x5 -> `wb_valid` one cycle later with w_data = 0x1234 and w_ena = 1. Repeat with x0 -> w_ena = 0.
- SB 0xAB at addr 0x1003 -> dreq_addr = 0x1000, wstrb = 0x08, wdata[31:24] = 0xAB, wen = 1. Hold `dreq_ready` low 3 cycles -> request stays stable.
- LB at addr 0x2005 with rdata = 0x0000_80FF_0000_0000 -> w_data = 0xFFFF_FFFF_FFFF_FF80. The same read as LBU -> w_data = 0x80.
- LW at addr 0x3002 -> no `dreq_valid`, and `wb_valid` arrives with `misalign` = 1 and w_ena = 0.
- LD: assert `rst_n` low while in RESP, then pulse `drsp_valid` after reset -> state IDLE, no `wb_valid`, all outputs 0.
- Back-to-back non-memory instructions on consecutive cycles -> `in_ready` stays 1 and `wb_valid` pulses each cycle. A following SD with 0-cycle memory latency -> `wb_valid` 3 cycles after acceptance.
